// File: rtl/hex_seg_p2s.sv
// Hex-to-7-segment encoder feeding a 64-bit MSB-first serial shifter for an external register chain.
// Start edge to done: 1 + 2*DIV*64 cycles; start is ignored while busy, no input backpressure otherwise.
module hex_seg_p2s #(
   parameter int DIV   = 2,
   parameter int NBITS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] hex_data,
   input  logic [7:0]  point,
   input  logic [7:0]  le,
   output logic        busy,
   output logic        done,
   output logic        sclk,
   output logic        sdat,
   output logic        slatch
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [NBITS-1:0]   frame_q, frame_d;
   logic [NBITS-1:0]   enc_frame;
   logic [5:0]         bit_q, bit_d;
   logic [7:0]         div_q, div_d;
   logic               sclk_q, sclk_d;
   logic               sdat_q, sdat_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               slatch_q, slatch_d;

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      s = 7'h00;
      case (nib)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Active-low digit bytes; a disabled digit is fully dark, dp included.
   always_comb begin
      enc_frame = '0;
      for (int k = 0; k < 8; k++) begin
         enc_frame[8*k +: 8] = le[k] ? ~{point[k], seg7(hex_data[4*k +: 4])} : 8'hFF;
      end
   end

   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      bit_d    = bit_q;
      div_d    = div_q;
      sclk_d   = sclk_q;
      sdat_d   = sdat_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      slatch_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            sclk_d = 1'b0;
            sdat_d = 1'b0;
            if (start) begin
               frame_d = enc_frame;
               sdat_d  = enc_frame[NBITS-1];
               busy_d  = 1'b1;
               bit_d   = '0;
               div_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (div_q == 8'(DIV - 1)) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               // Falling edge: either advance to the next bit or close the frame.
               if (sclk_q) begin
                  if (bit_q == 6'(NBITS - 1)) begin
                     sclk_d   = 1'b0;
                     sdat_d   = 1'b0;
                     done_d   = 1'b1;
                     slatch_d = 1'b1;
                     state_d  = S_DONE;
                  end else begin
                     frame_d = {frame_q[NBITS-2:0], 1'b0};
                     sdat_d  = frame_q[NBITS-2];
                     bit_d   = bit_q + 6'd1;
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            sdat_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         frame_q  <= '0;
         bit_q    <= '0;
         div_q    <= '0;
         sclk_q   <= 1'b0;
         sdat_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         slatch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         bit_q    <= bit_d;
         div_q    <= div_d;
         sclk_q   <= sclk_d;
         sdat_q   <= sdat_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         slatch_q <= slatch_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign sclk   = sclk_q;
   assign sdat   = sdat_q;
   assign slatch = slatch_q;

endmodule
